// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WAIT_DISCARD = 2'd2,
    ST_HALTED       = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [15:0] HALT_INSTR  = 16'h0000;
  localparam int unsigned INSTR_BYTES = 32'd2;

endpackage

// File: rtl/fetch_prefetch_q_fifo.sv
// Synchronous prefetch FIFO with flush; head entry is presented combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_pop_s;

  assign do_pop_s = pop & ~empty;
  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == {(AW+1){1'b0}});
  assign count    = count_r;
  assign rdata    = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (push && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_prefetch_q.sv
// Instruction-fetch stage: one-outstanding imem handshake feeding a prefetch
// queue that drives the IF/ID register; flushes on redirect, stops at HALT.
module fetch_prefetch_q
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_stall,
  input  logic              imem_done,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              takeBranch_EXMEM,
  input  logic [ADDR_W-1:0] PCS,
  input  logic              stallCtrl,
  output logic [DATA_W-1:0] instr_IFID,
  output logic [ADDR_W-1:0] PC2_IFID,
  output logic              valid_IFID,
  output logic              halt_IFID,
  output logic              err
);

  localparam int CW = $clog2(DEPTH);
  localparam int QW = DATA_W + ADDR_W;

  fetch_state_e      state_r, state_nxt_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [ADDR_W:0]   pc_inc_s;
  logic              req_s, push_s, pop_s, full_s, empty_s;
  logic [CW:0]       count_s;
  logic [QW-1:0]     head_s;
  logic [DATA_W-1:0] head_instr_s;
  logic [ADDR_W-1:0] head_pc2_s;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] pc2_r;
  logic              valid_r, halt_r, err_r;

  // Extra top bit catches the carry out of the PC increment.
  assign pc_inc_s  = {1'b0, fetch_pc_r} + (ADDR_W+1)'(INSTR_BYTES);
  assign req_s     = (state_r == ST_IDLE) && (count_s < (CW+1)'(DEPTH)) && !takeBranch_EXMEM;
  assign imem_rd   = req_s & ~rst;
  assign imem_addr = fetch_pc_r;
  assign push_s    = (state_r == ST_WAIT) & imem_done & ~takeBranch_EXMEM & (~full_s | pop_s);
  assign pop_s     = ~takeBranch_EXMEM & ~stallCtrl & ~empty_s;
  assign {head_instr_s, head_pc2_s} = head_s;

  fetch_fifo #(.W(QW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (takeBranch_EXMEM),
    .wdata ({imem_data, pc_inc_s[ADDR_W-1:0]}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Next-state and next-PC; a redirect overrides every other transition.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    if (takeBranch_EXMEM) begin
      fetch_pc_nxt_s = PCS;
      case (state_r)
        ST_WAIT, ST_WAIT_DISCARD: state_nxt_s = imem_done ? ST_IDLE : ST_WAIT_DISCARD;
        default:                  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && !imem_stall) state_nxt_s = ST_WAIT;
          else                      state_nxt_s = ST_IDLE;
        end
        ST_WAIT: begin
          if (imem_done) begin
            fetch_pc_nxt_s = pc_inc_s[ADDR_W-1:0];
            state_nxt_s    = (imem_data == DATA_W'(HALT_INSTR)) ? ST_HALTED : ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_WAIT_DISCARD: begin
          if (imem_done) state_nxt_s = ST_IDLE;
          else           state_nxt_s = ST_WAIT_DISCARD;
        end
        ST_HALTED: state_nxt_s = ST_HALTED;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
    end
  end

  // IF/ID register: bubble on redirect or empty queue, hold under hazard stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r <= DATA_W'(NOP_INSTR);
      pc2_r   <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
      halt_r  <= 1'b0;
    end else if (takeBranch_EXMEM) begin
      instr_r <= DATA_W'(NOP_INSTR);
      valid_r <= 1'b0;
      halt_r  <= 1'b0;
    end else if (!stallCtrl) begin
      if (!empty_s) begin
        instr_r <= head_instr_s;
        pc2_r   <= head_pc2_s;
        valid_r <= 1'b1;
        halt_r  <= (head_instr_s == DATA_W'(HALT_INSTR));
      end else begin
        instr_r <= DATA_W'(NOP_INSTR);
        valid_r <= 1'b0;
        halt_r  <= 1'b0;
      end
    end
  end

  // Sticky error: PC wrap on increment, or misaligned redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= err_r | (takeBranch_EXMEM & PCS[0]) | (push_s & pc_inc_s[ADDR_W]);
  end

  assign instr_IFID = instr_r;
  assign PC2_IFID   = pc2_r;
  assign valid_IFID = valid_r;
  assign halt_IFID  = halt_r;
  assign err        = err_r;

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Directed bench for fetch_prefetch_q with a behavioural instruction memory.
module tb_fetch_prefetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall = 1'b0;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        takeBranch_EXMEM = 1'b0;
  logic [15:0] PCS = 16'h0000;
  logic        stallCtrl = 1'b0;
  logic [15:0] instr_IFID, PC2_IFID;
  logic        valid_IFID, halt_IFID, err;

  logic        rd2, done2 = 1'b0, valid2, halt2, err2, acc2 = 1'b0;
  logic [15:0] addr2, instr2, pc2_2;
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = 16'h0000;
  logic [15:0] data2 = 16'h1234;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  int          lat = 1;
  int          pend = 0;
  logic [15:0] pend_data = 16'h0000;
  logic        acc = 1'b0;
  logic [15:0] acc_addr = 16'h0000;
  logic [15:0] req_addr [64];
  int          req_cnt = 0;

  always #5 clk = ~clk;

  fetch_prefetch_q dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_stall(imem_stall), .imem_done(imem_done), .imem_data(imem_data),
    .takeBranch_EXMEM(takeBranch_EXMEM), .PCS(PCS), .stallCtrl(stallCtrl),
    .instr_IFID(instr_IFID), .PC2_IFID(PC2_IFID), .valid_IFID(valid_IFID),
    .halt_IFID(halt_IFID), .err(err)
  );

  fetch_prefetch_q #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_rd(rd2), .imem_addr(addr2),
    .imem_stall(zero1), .imem_done(done2), .imem_data(data2),
    .takeBranch_EXMEM(zero1), .PCS(zero16), .stallCtrl(zero1),
    .instr_IFID(instr2), .PC2_IFID(pc2_2), .valid_IFID(valid2),
    .halt_IFID(halt2), .err(err2)
  );

  // Memory for dut: sample request just before the edge, answer after it.
  always begin
    @(negedge clk); #4;
    acc = imem_rd && !imem_stall && !rst;
    acc_addr = imem_addr;
    @(posedge clk); #1;
    imem_done = 1'b0;
    if (rst) begin
      pend = 0;
      req_cnt = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin imem_done = 1'b1; imem_data = pend_data; end
      end
      if (acc) begin
        if (req_cnt < 64) req_addr[req_cnt] = acc_addr;
        req_cnt++;
        pend_data = mem[acc_addr[8:1]];
        if (lat <= 1) begin imem_done = 1'b1; imem_data = pend_data; end
        else pend = lat - 1;
      end
    end
  end

  // Memory for dut2: always ready, one-cycle latency, constant data.
  always begin
    @(negedge clk); #4;
    acc2 = rd2 && !rst;
    @(posedge clk); #1;
    done2 = acc2;
  end

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; takeBranch_EXMEM = 1'b0; PCS = 16'h0000; stallCtrl = 1'b0; imem_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", imem_rd); end
    checks++; if (instr_IFID !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h want 0800", instr_IFID); end
    checks++; if (PC2_IFID !== 16'h0000) begin errors++; $display("FAIL reset_pc2: got %h want 0000", PC2_IFID); end
    checks++; if ({valid_IFID, halt_IFID, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {valid_IFID, halt_IFID, err}); end
    checks++; if ({rd2, err2} !== 2'b00) begin errors++; $display("FAIL reset_dut2: got %b want 00", {rd2, err2}); end
  endtask

  task automatic test_basic();
    logic rd_seen;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h0000; lat = 1;
    do_reset();
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL basic_req0: got %b/%h want 1/0000", imem_rd, imem_addr); end
    next_cyc();
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL basic_wait_rd: got %b want 0", imem_rd); end
    next_cyc();
    checks++; if ({imem_rd, imem_addr, valid_IFID} !== {1'b1, 16'h0002, 1'b0}) begin errors++; $display("FAIL basic_req1: got %b/%h/%b want 1/0002/0", imem_rd, imem_addr, valid_IFID); end
    next_cyc();
    checks++; if ({valid_IFID, instr_IFID, PC2_IFID} !== {1'b1, 16'h1111, 16'h0002}) begin errors++; $display("FAIL basic_if0: got %b/%h/%h want 1/1111/0002", valid_IFID, instr_IFID, PC2_IFID); end
    next_cyc();
    checks++; if ({valid_IFID, instr_IFID, PC2_IFID} !== {1'b0, 16'h0800, 16'h0002}) begin errors++; $display("FAIL basic_bubble: got %b/%h/%h want 0/0800/0002", valid_IFID, instr_IFID, PC2_IFID); end
    next_cyc();
    checks++; if ({valid_IFID, instr_IFID, PC2_IFID} !== {1'b1, 16'h2222, 16'h0004}) begin errors++; $display("FAIL basic_if1: got %b/%h/%h want 1/2222/0004", valid_IFID, instr_IFID, PC2_IFID); end
    next_cyc();
    next_cyc();
    checks++; if ({valid_IFID, halt_IFID, instr_IFID, PC2_IFID} !== {2'b11, 16'h0000, 16'h0006}) begin errors++; $display("FAIL basic_halt: got %b%b/%h/%h want 11/0000/0006", valid_IFID, halt_IFID, instr_IFID, PC2_IFID); end
    rd_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin next_cyc(); rd_seen = rd_seen | imem_rd; end
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL basic_halted_rd: got %b want 0", rd_seen); end
    checks++; if (halt_IFID !== 1'b0) begin errors++; $display("FAIL basic_halt_clear: got %b want 0", halt_IFID); end
    checks++; if (req_cnt !== 3) begin errors++; $display("FAIL basic_req_cnt: got %0d want 3", req_cnt); end
  endtask

  task automatic test_imem_stall();
    mem[0] = 16'h0000; lat = 1;
    do_reset();
    imem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL mstall_hold%0d: got %b/%h want 1/0000", i, imem_rd, imem_addr); end
      if (i < 2) next_cyc();
    end
    imem_stall = 1'b0;
    checks++; if (req_cnt !== 0) begin errors++; $display("FAIL mstall_noacc: got %0d want 0", req_cnt); end
    next_cyc();
    checks++; if ({imem_rd, req_cnt[7:0]} !== {1'b0, 8'd1}) begin errors++; $display("FAIL mstall_acc: got %b/%0d want 0/1", imem_rd, req_cnt); end
  endtask

  task automatic test_stall();
    logic [15:0] exp_i [5];
    exp_i = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    for (int i = 0; i < 5; i++) mem[i] = exp_i[i];
    mem[5] = 16'h0000; lat = 1;
    do_reset();
    stallCtrl = 1'b1;
    for (int i = 0; i < 9; i++) next_cyc();
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL stall_req_cnt: got %0d want 4", req_cnt); end
    checks++; if ({req_addr[0], req_addr[1], req_addr[2], req_addr[3]} !== {16'h0000, 16'h0002, 16'h0004, 16'h0006})
      begin errors++; $display("FAIL stall_addrs: got %h %h %h %h want 0000 0002 0004 0006", req_addr[0], req_addr[1], req_addr[2], req_addr[3]); end
    checks++; if ({imem_rd, valid_IFID, instr_IFID} !== {2'b00, 16'h0800}) begin errors++; $display("FAIL stall_bubble: got %b/%b/%h want 0/0/0800", imem_rd, valid_IFID, instr_IFID); end
    next_cyc();
    stallCtrl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      checks++; if ({valid_IFID, instr_IFID, PC2_IFID} !== {1'b1, exp_i[i], 16'(2 * (i + 1))})
        begin errors++; $display("FAIL stall_pop%0d: got %b/%h/%h want 1/%h/%h", i, valid_IFID, instr_IFID, PC2_IFID, exp_i[i], 16'(2 * (i + 1))); end
    end
  endtask

  task automatic collect(input int ncyc, input logic [15:0] bad, output int n, output logic stale,
                         output logic [15:0] i0, output logic [15:0] p0, output logic [15:0] i1);
    n = 0; stale = 1'b0; i0 = 16'hxxxx; p0 = 16'hxxxx; i1 = 16'hxxxx;
    for (int c = 0; c < ncyc; c++) begin
      next_cyc();
      if (valid_IFID) begin
        if (instr_IFID == bad) stale = 1'b1;
        if (n == 0) begin i0 = instr_IFID; p0 = PC2_IFID; end
        if (n == 1) i1 = instr_IFID;
        n++;
      end
    end
  endtask

  task automatic test_redirect_wait();
    int n; logic stale; logic [15:0] i0, p0, i1;
    mem[0] = 16'h3333; mem[8'h20] = 16'h4444; mem[8'h21] = 16'h0000; lat = 3;
    do_reset();
    next_cyc();
    takeBranch_EXMEM = 1'b1; PCS = 16'h0040;
    next_cyc();
    takeBranch_EXMEM = 1'b0; #1;
    checks++; if ({imem_rd, valid_IFID} !== 2'b00) begin errors++; $display("FAIL rdw_discard: got %b/%b want 0/0", imem_rd, valid_IFID); end
    next_cyc();
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rdw_done_cycle_rd: got %b want 0", imem_rd); end
    next_cyc();
    lat = 1;
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0040}) begin errors++; $display("FAIL rdw_newreq: got %b/%h want 1/0040", imem_rd, imem_addr); end
    collect(10, 16'h3333, n, stale, i0, p0, i1);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rdw_stale: got %b want 0", stale); end
    checks++; if ({n[3:0], i0, p0, i1} !== {4'd2, 16'h4444, 16'h0042, 16'h0000}) begin errors++; $display("FAIL rdw_stream: got %0d/%h/%h/%h want 2/4444/0042/0000", n, i0, p0, i1); end
    checks++; if (req_cnt !== 3) begin errors++; $display("FAIL rdw_req_cnt: got %0d want 3", req_cnt); end
  endtask

  task automatic test_redirect_done();
    int n; logic stale; logic [15:0] i0, p0, i1;
    mem[0] = 16'h5555; mem[8'h10] = 16'h6666; mem[8'h11] = 16'h0000; lat = 1;
    do_reset();
    next_cyc();
    takeBranch_EXMEM = 1'b1; PCS = 16'h0020;
    next_cyc();
    takeBranch_EXMEM = 1'b0; #1;
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL rdd_newreq: got %b/%h want 1/0020", imem_rd, imem_addr); end
    collect(8, 16'h5555, n, stale, i0, p0, i1);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rdd_stale: got %b want 0", stale); end
    checks++; if ({n[3:0], i0, p0, i1} !== {4'd2, 16'h6666, 16'h0022, 16'h0000}) begin errors++; $display("FAIL rdd_stream: got %0d/%h/%h/%h want 2/6666/0022/0000", n, i0, p0, i1); end
  endtask

  task automatic test_halt_redirect();
    mem[0] = 16'h0000; mem[8] = 16'h7777; mem[9] = 16'h0000; lat = 1;
    do_reset();
    next_cyc(); next_cyc(); next_cyc();
    checks++; if ({halt_IFID, imem_rd} !== 2'b10) begin errors++; $display("FAIL hr_halted: got %b%b want 10", halt_IFID, imem_rd); end
    next_cyc();
    takeBranch_EXMEM = 1'b1; PCS = 16'h0010;
    next_cyc();
    takeBranch_EXMEM = 1'b0; #1;
    checks++; if ({imem_rd, imem_addr, valid_IFID, halt_IFID} !== {1'b1, 16'h0010, 2'b00}) begin errors++; $display("FAIL hr_resume: got %b/%h/%b%b want 1/0010/00", imem_rd, imem_addr, valid_IFID, halt_IFID); end
    next_cyc(); next_cyc(); next_cyc();
    checks++; if ({valid_IFID, halt_IFID, instr_IFID, PC2_IFID} !== {2'b10, 16'h7777, 16'h0012}) begin errors++; $display("FAIL hr_instr: got %b%b/%h/%h want 10/7777/0012", valid_IFID, halt_IFID, instr_IFID, PC2_IFID); end
  endtask

  task automatic test_err();
    mem[9] = 16'h0000; lat = 1;
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", err); end
    takeBranch_EXMEM = 1'b1; PCS = 16'h0013;
    next_cyc();
    takeBranch_EXMEM = 1'b0; #1;
    checks++; if ({err, imem_rd, imem_addr} !== {2'b11, 16'h0013}) begin errors++; $display("FAIL err_misalign: got %b/%b/%h want 1/1/0013", err, imem_rd, imem_addr); end
    next_cyc(); next_cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst_clear: got %b want 0", err); end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if ({rd2, addr2, err2} !== {1'b1, 16'hFFFC, 1'b0}) begin errors++; $display("FAIL wrap_req0: got %b/%h/%b want 1/FFFC/0", rd2, addr2, err2); end
    next_cyc(); next_cyc();
    checks++; if ({rd2, addr2, err2} !== {1'b1, 16'hFFFE, 1'b0}) begin errors++; $display("FAIL wrap_req1: got %b/%h/%b want 1/FFFE/0", rd2, addr2, err2); end
    next_cyc();
    checks++; if ({err2, instr2, pc2_2} !== {1'b0, 16'h1234, 16'hFFFE}) begin errors++; $display("FAIL wrap_pre: got %b/%h/%h want 0/1234/FFFE", err2, instr2, pc2_2); end
    next_cyc();
    checks++; if ({err2, rd2, addr2} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL wrap_err: got %b/%b/%h want 1/1/0000", err2, rd2, addr2); end
    next_cyc();
    checks++; if ({valid2, pc2_2} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_pc2: got %b/%h want 1/0000", valid2, pc2_2); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL wrap_rst_clear: got %b want 0", err2); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_imem_stall();
    test_stall();
    test_redirect_wait();
    test_redirect_done();
    test_halt_redirect();
    test_err();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
